// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_pkg
//  Brief    : Shared widths, bus typedefs and master state encoding for the
//             simple bus slave interface and its read master.
//  Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

  localparam int BUS_ADDR_W = 4;
  localparam int BUS_DATA_W = 32;

  typedef logic [BUS_ADDR_W-1:0] bus_adr_t;
  typedef logic [BUS_DATA_W-1:0] bus_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    GAP   = 2'd3
  } master_state_t;

  // Bits needed to hold the larger of the two phase lengths.
  function automatic int cnt_width(input int hold, input int gap);
    int mx;
    mx = (hold > gap) ? hold : gap;
    return $clog2(mx + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wait_counter.sv
`default_nettype none
// ============================================================================
//  Module   : wait_counter
//  Brief    : Loadable down-counter with a zero flag; saturates at zero.
//  Revision : 1.0 - initial release
// ============================================================================
module wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  // Load takes priority over decrement; counting stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/bus_read_master.sv
`default_nettype none
// ============================================================================
//  Module   : bus_read_master
//  Brief    : Host-facing read requester. Holds rd/adr for HOLD_CYCLES so a
//             divided-clock slave can latch data, samples bus_d on the last
//             hold cycle and returns it over a valid/ready response channel.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_read_master
  import bus_pkg::*;
#(
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_adr,
  output logic              req_ready,
  output logic              rd,
  output logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] bus_d,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_adr,
  output logic              busy
);

  localparam int               CNT_W     = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic             HAS_GAP   = (GAP_CYCLES > 0);

  generate
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("bus_read_master: HOLD_CYCLES must be at least 1");
    end
  endgenerate

  master_state_t     state_q, state_d;
  logic              cnt_load_d;
  logic [CNT_W-1:0]  cnt_load_val_d;
  logic              cnt_dec_d;
  logic              cnt_zero;
  logic [ADDR_W-1:0] adr_q;
  logic [ADDR_W-1:0] rsp_adr_q;
  logic [DATA_W-1:0] rsp_data_q;

  // One shared counter times both the rd hold window and the idle gap.
  wait_counter #(
    .WIDTH (CNT_W)
  ) u_wait_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load_d),
    .load_val_i (cnt_load_val_d),
    .dec_i      (cnt_dec_d),
    .zero_o     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_d        = state_q;
    cnt_load_d     = 1'b0;
    cnt_load_val_d = '0;
    cnt_dec_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d        = ISSUE;
          cnt_load_d     = 1'b1;
          cnt_load_val_d = HOLD_LOAD;
        end
      end
      ISSUE: begin
        cnt_dec_d = 1'b1;
        if (cnt_zero) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (HAS_GAP) begin
            state_d        = GAP;
            cnt_load_d     = 1'b1;
            cnt_load_val_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        cnt_dec_d = 1'b1;
        if (cnt_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address latches on acceptance; data is sampled in the final hold cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q      <= '0;
      rsp_adr_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      if ((state_q == IDLE) && req_valid) begin
        adr_q     <= req_adr;
        rsp_adr_q <= req_adr;
      end
      if ((state_q == ISSUE) && cnt_zero) begin
        rsp_data_q <= bus_d;
      end
    end
  end

  assign req_ready = rst_n & (state_q == IDLE);
  assign rd        = (state_q == ISSUE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign adr       = adr_q;
  assign rsp_adr   = rsp_adr_q;
  assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_read_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_read_master
//  Brief    : Directed and randomized checks of bus_read_master timing,
//             sampling, backpressure and reset behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_read_master;

  localparam int HOLD = 8;
  localparam int GAPC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [3:0]  req_adr;
  logic        req_ready;
  logic        rd;
  logic [3:0]  adr;
  logic [31:0] bus_d;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_adr;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int low_run = 0;
  int last_low = 0;

  bus_read_master #(
    .ADDR_W      (4),
    .DATA_W      (32),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAPC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_adr   (req_adr),
    .req_ready (req_ready),
    .rd        (rd),
    .adr       (adr),
    .bus_d     (bus_d),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_adr   (rsp_adr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Length of the most recent rd-low stretch preceding an rd pulse.
  always @(posedge clk) begin
    if (rd) begin
      if (low_run > 0) last_low = low_run;
      low_run = 0;
    end else begin
      low_run = low_run + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full read: wait for acceptance, check the hold window, sample point,
  // backpressure behaviour and gap, ending on the first IDLE cycle after it.
  task automatic read_txn(input logic [3:0] a, input logic [31:0] d_early,
                          input logic [31:0] d_last, input int delay,
                          input logic keep_valid, input logic [3:0] next_adr);
    int waited;
    waited    = 0;
    req_valid = 1'b1;
    req_adr   = a;
    while (!req_ready && waited < 50) begin
      step();
      waited++;
    end
    chk("accept_ready", {63'd0, req_ready}, 64'd1);
    chk("accept_rd_low", {63'd0, rd}, 64'd0);
    step();
    req_valid = keep_valid;
    req_adr   = next_adr;
    for (int i = 1; i <= HOLD; i++) begin
      bus_d = (i == HOLD) ? d_last : d_early;
      chk($sformatf("hold%0d_rd", i), {63'd0, rd}, 64'd1);
      chk($sformatf("hold%0d_adr", i), {60'd0, adr}, {60'd0, a});
      chk($sformatf("hold%0d_rspv", i), {63'd0, rsp_valid}, 64'd0);
      chk($sformatf("hold%0d_ready", i), {63'd0, req_ready}, 64'd0);
      step();
    end
    bus_d = ~d_last;
    for (int k = 0; k <= delay; k++) begin
      rsp_ready = (k == delay);
      chk("resp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("resp_data", {32'd0, rsp_data}, {32'd0, d_last});
      chk("resp_adr", {60'd0, rsp_adr}, {60'd0, a});
      chk("resp_rd", {63'd0, rd}, 64'd0);
      chk("resp_ready", {63'd0, req_ready}, 64'd0);
      step();
    end
    rsp_ready = 1'b0;
    for (int g = 0; g < GAPC; g++) begin
      chk("gap_busy", {63'd0, busy}, 64'd1);
      chk("gap_rd", {63'd0, rd}, 64'd0);
      chk("gap_ready", {63'd0, req_ready}, 64'd0);
      chk("gap_rspv", {63'd0, rsp_valid}, 64'd0);
      step();
    end
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_ready", {63'd0, req_ready}, 64'd1);
    chk("idle_adr_kept", {60'd0, adr}, {60'd0, a});
  endtask

  initial begin
    logic [3:0]  ra;
    logic [31:0] rd0, rd1;
    int          rdly;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_adr   = '0;
    bus_d     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("por_rd", {63'd0, rd}, 64'd0);
    chk("por_ready", {63'd0, req_ready}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("por_release_ready", {63'd0, req_ready}, 64'd1);
    step();

    // Single read with the canonical pattern.
    read_txn(4'h5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1'b0, 4'h0);

    // Mid-simulation reset from an idle-but-used state.
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_rd", {63'd0, rd}, 64'd0);
    chk("rst_adr", {60'd0, adr}, 64'd0);
    chk("rst_rspv", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rspdata", {32'd0, rsp_data}, 64'd0);
    chk("rst_rspadr", {60'd0, rsp_adr}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready_low", {63'd0, req_ready}, 64'd0);
    step();
    rsp_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_ready", {63'd0, req_ready}, 64'd1);
    step();
    chk("rel_ready_next", {63'd0, req_ready}, 64'd1);

    // Sample point is the last hold cycle only.
    read_txn(4'h1, 32'h11111111, 32'h22222222, 0, 1'b0, 4'h0);

    // Backpressure with a pending request behind it.
    read_txn(4'h6, 32'h0BADF00D, 32'hCAFEF00D, 5, 1'b1, 4'hA);
    read_txn(4'hA, 32'h5A5A5A5A, 32'hA5A5A5A5, 0, 1'b0, 4'h0);

    // Back-to-back with req_valid held high.
    read_txn(4'h3, 32'h33333333, 32'h30303030, 0, 1'b1, 4'h7);
    read_txn(4'h7, 32'h77777777, 32'h70707070, 0, 1'b0, 4'h0);
    chk("b2b_rd_low", 64'(last_low), 64'(GAPC + 2));

    // Randomized reads.
    for (int n = 0; n < 6; n++) begin
      ra   = 4'($urandom);
      rd0  = $urandom;
      rd1  = $urandom;
      rdly = int'($urandom_range(0, 3));
      read_txn(ra, rd0, rd1, rdly, 1'b0, 4'h0);
    end

    // Reset in hold cycle 4 of a read to address 2.
    req_valid = 1'b1;
    req_adr   = 4'h2;
    chk("r6_ready", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
    for (int i = 1; i < 4; i++) step();
    chk("r6_rd_before", {63'd0, rd}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r6_rd_drop", {63'd0, rd}, 64'd0);
    chk("r6_rspv_drop", {63'd0, rsp_valid}, 64'd0);
    chk("r6_busy_drop", {63'd0, busy}, 64'd0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("r6_no_rsp", {63'd0, rsp_valid}, 64'd0);
      chk("r6_idle", {63'd0, busy}, 64'd0);
    end
    chk("r6_ready_after", {63'd0, req_ready}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
